// File: rtl/trace_uart_scheduler_if.sv
// ---------------------------------------------------------------------------
// trace_uart_scheduler_if
//
// Groups the two byte/frame handshakes of the trace UART scheduler.
//   frame_valid / frame_data / frame_ready : 128-bit TPIU frame from the aligner
//   tx_data / tx_valid / tx_ready          : byte stream to the UART serializer
//
// Modports:
//   master : the scheduler (consumes frames, drives the UART byte stream)
//   slave  : its environment (frame aligner + UART transmitter)
// ---------------------------------------------------------------------------
interface trace_uart_scheduler_if;
    logic         frame_valid;
    logic [127:0] frame_data;
    logic         frame_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        input  frame_valid, frame_data, tx_ready,
        output frame_ready, tx_data, tx_valid
    );

    modport slave (
        output frame_valid, frame_data, tx_ready,
        input  frame_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/trace_uart_scheduler.sv
// ---------------------------------------------------------------------------
// trace_uart_scheduler
//
// Sequences the UART transmit path of orbtrace. 16-byte TPIU frames are
// buffered in a one-deep holding register and sent as 17-byte FRAME packets
// (0x5A + payload). They are interleaved with 4-byte STATUS packets
// (0xA5, status, drop[15:8], drop[7:0]) raised by a heartbeat timer or by a
// change of sync / cfg_width. Frames arriving while the holding register is
// full are counted as drops and raise the sticky txOvf flag.
//
// Ports:
//   clk         system clock (12 MHz)
//   rst         asynchronous reset, active-low
//   bus         frame input and UART byte output handshakes (master modport)
//   sync        trace port synchronised
//   cfg_width   trace width code, reported in the status byte
//   txOvf       sticky overflow flag, cleared when a STATUS packet completes
//   frame_count wrapping count of completely transmitted frames
// ---------------------------------------------------------------------------
module trace_uart_scheduler #(
    parameter int HB_PERIOD = 12000000,
    parameter int DROP_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    trace_uart_scheduler_if.master        bus,
    input  logic                          sync,
    input  logic [1:0]                    cfg_width,
    output logic                          txOvf,
    output logic [7:0]                    frame_count
);

    localparam int              HB_W        = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam logic [HB_W-1:0] HB_LAST     = HB_W'(HB_PERIOD - 1);
    localparam logic [7:0]      FRAME_HDR   = 8'h5A;
    localparam logic [7:0]      STATUS_HDR  = 8'hA5;
    localparam logic [4:0]      FRAME_LAST  = 5'd16;
    localparam logic [4:0]      STATUS_LAST = 5'd3;

    typedef enum logic [1:0] {
        IDLE,
        STATUS,
        FRAME
    } state_t;

    state_t            state, state_next;
    logic [4:0]        idx, idx_next;
    logic              tx_valid_q, tx_valid_next;

    logic              hold_full;
    logic [127:0]      hold_data;
    logic [DROP_W-1:0] drop_cnt;
    logic [HB_W-1:0]   hb_cnt;
    logic              status_pending;
    logic              after_status;
    logic              sync_q;
    logic [1:0]        cfg_q;
    logic [7:0]        status_snap;
    logic [15:0]       drop_snap;
    logic [15:0]       drop_ext;
    logic [7:0]        tx_byte;
    logic [3:0]        byte_sel;

    logic accept, last_byte, pkt_done, status_done, frame_done;
    logic start_status, start_frame;
    logic drop, load, trigger;

    assign accept      = tx_valid_q && bus.tx_ready;
    assign last_byte   = (state == FRAME) ? (idx == FRAME_LAST) : (idx == STATUS_LAST);
    assign pkt_done    = accept && last_byte;
    assign status_done = pkt_done && (state == STATUS);
    assign frame_done  = pkt_done && (state == FRAME);

    // Upstream shows each frame for exactly one cycle, so a refused cycle is a lost frame.
    assign drop = bus.frame_valid && hold_full;
    assign load = bus.frame_valid && !hold_full;

    assign trigger = (hb_cnt == HB_LAST) || (sync != sync_q) || (cfg_width != cfg_q);

    // Drop count reported in the status packet is always 16 bits wide.
    generate
        if (DROP_W >= 16) begin : g_drop_trunc
            assign drop_ext = drop_cnt[15:0];
        end else begin : g_drop_ext
            assign drop_ext = {{(16 - DROP_W){1'b0}}, drop_cnt};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            tx_valid_q <= tx_valid_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Scheduling decisions are taken in IDLE only, so a
    // packet in flight is never interrupted. tx_valid rises one cycle after
    // a packet state is entered and falls when the last byte is taken.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // can infer a latch.
        state_next    = state;
        idx_next      = idx;
        tx_valid_next = 1'b0;
        start_status  = 1'b0;
        start_frame   = 1'b0;
        case (state)
            IDLE: begin
                idx_next = '0;
                // A held frame goes ahead of a pending status right after a
                // status packet, so heartbeats cannot starve the frame path.
                if (status_pending && !(after_status && hold_full)) begin
                    state_next   = STATUS;
                    start_status = 1'b1;
                end else if (hold_full) begin
                    state_next  = FRAME;
                    start_frame = 1'b1;
                end
            end
            default: begin
                tx_valid_next = 1'b1;
                if (accept) begin
                    if (last_byte) begin
                        state_next    = IDLE;
                        tx_valid_next = 1'b0;
                    end else begin
                        idx_next = idx + 5'd1;
                    end
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The byte is a pure function of state, idx and the
    // packet snapshots, so it stays put while the UART stalls.
    // ------------------------------------------------------------------
    assign byte_sel = idx[3:0] - 4'd1;  // idx 1..16 -> payload byte 0..15

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            STATUS: begin
                case (idx)
                    5'd0:    tx_byte = STATUS_HDR;
                    5'd1:    tx_byte = status_snap;
                    5'd2:    tx_byte = drop_snap[15:8];
                    default: tx_byte = drop_snap[7:0];
                endcase
            end
            FRAME: begin
                tx_byte = (idx == 5'd0) ? FRAME_HDR : hold_data[{byte_sel, 3'b000} +: 8];
            end
            default: tx_byte = 8'h00;
        endcase
    end

    assign bus.tx_data     = tx_byte;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.frame_ready = !hold_full;

    // ------------------------------------------------------------------
    // Frame payload
    // ------------------------------------------------------------------
    // NOTE: the payload has no reset; hold_full alone says whether it holds
    // a frame.
    always_ff @(posedge clk) begin
        if (load) begin
            hold_data <= bus.frame_data;
        end
    end

    // ------------------------------------------------------------------
    // Control and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full      <= 1'b0;
            drop_cnt       <= '0;
            txOvf          <= 1'b0;
            frame_count    <= 8'd0;
            status_pending <= 1'b1;
            after_status   <= 1'b0;
            hb_cnt         <= '0;
            sync_q         <= 1'b0;
            cfg_q          <= 2'd0;
            status_snap    <= 8'd0;
            drop_snap      <= 16'd0;
        end else begin
            // A frame cannot load in its predecessor's last cycle: frame_ready
            // is still low then.
            if (load) begin
                hold_full <= 1'b1;
            end else if (frame_done) begin
                hold_full <= 1'b0;
            end

            // Packet start clears the counter; a drop in that cycle counts after it.
            if (start_status) begin
                drop_cnt <= drop ? DROP_W'(1) : '0;
            end else if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end

            // A drop in the completion cycle of a status packet keeps the flag set.
            if (drop) begin
                txOvf <= 1'b1;
            end else if (status_done) begin
                txOvf <= 1'b0;
            end

            if (frame_done) begin
                frame_count <= frame_count + 8'd1;
            end

            // A trigger in the start cycle schedules a further status packet.
            if (trigger) begin
                status_pending <= 1'b1;
            end else if (start_status) begin
                status_pending <= 1'b0;
            end

            if (status_done) begin
                after_status <= 1'b1;
            end else if (start_frame) begin
                after_status <= 1'b0;
            end

            hb_cnt <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + HB_W'(1);
            sync_q <= sync;
            cfg_q  <= cfg_width;

            if (start_status) begin
                status_snap <= {sync, cfg_width, txOvf, frame_count[3:0]};
                drop_snap   <= drop_ext;
            end
        end
    end

endmodule

// File: tb/tb_trace_uart_scheduler.sv
// ---------------------------------------------------------------------------
// tb_trace_uart_scheduler
//
// Directed scenarios followed by a randomized run. A packet-level reference
// model (byte queue per packet, plain counters for drops, heartbeat and
// flags) predicts every cycle's tx_valid / tx_data / frame_ready / txOvf /
// frame_count; directed scenarios add checks against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_trace_uart_scheduler;

    localparam int HB = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sync = 1'b0;
    logic [1:0] cfg_width = 2'd0;
    logic       txOvf;
    logic [7:0] frame_count;

    trace_uart_scheduler_if bus();

    trace_uart_scheduler #(
        .HB_PERIOD(HB),
        .DROP_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sync       (sync),
        .cfg_width  (cfg_width),
        .txOvf      (txOvf),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] log_q[$];   // bytes taken by the UART
    int         rise_q[$];  // cycles where tx_valid rose
    logic       prev_valid;

    // Reference model state
    logic [7:0]   m_pkt[$];
    bit           m_busy, m_valid, m_is_status, m_hold_full;
    bit           m_pending, m_after_status, m_ovf, m_sync_q;
    logic [1:0]   m_cfg_q;
    logic [127:0] m_hold;
    int           m_drop, m_hb;
    logic [7:0]   m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < log_q.size()) return {24'h0, log_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic model_reset();
        m_pkt.delete();
        m_busy = 0; m_valid = 0; m_is_status = 0; m_hold_full = 0;
        m_pending = 1; m_after_status = 0; m_ovf = 0; m_sync_q = 0;
        m_cfg_q = 2'd0; m_hold = '0; m_drop = 0; m_hb = 0; m_count = 8'd0;
        prev_valid = 1'b0;
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step();
        bit acc, drp, ld, trig;
        acc  = m_valid && bus.tx_ready;
        drp  = bus.frame_valid && m_hold_full;
        ld   = bus.frame_valid && !m_hold_full;
        trig = (m_hb == HB - 1) || (sync != m_sync_q) || (cfg_width != m_cfg_q);
        if (m_busy) begin
            if (!m_valid) begin
                m_valid = 1;
            end else if (acc) begin
                void'(m_pkt.pop_front());
                if (m_pkt.size() == 0) begin
                    m_busy = 0;
                    m_valid = 0;
                    if (m_is_status) begin
                        m_ovf = 0;
                        m_after_status = 1;
                    end else begin
                        m_count++;
                        m_hold_full = 0;
                    end
                end
            end
        end else if (m_pending && !(m_after_status && m_hold_full)) begin
            m_pkt.delete();
            m_pkt.push_back(8'hA5);
            m_pkt.push_back({sync, cfg_width, m_ovf, m_count[3:0]});
            m_pkt.push_back(m_drop[15:8]);
            m_pkt.push_back(m_drop[7:0]);
            m_drop = 0;
            m_pending = 0;
            m_busy = 1;
            m_is_status = 1;
        end else if (m_hold_full) begin
            m_pkt.delete();
            m_pkt.push_back(8'h5A);
            for (int k = 0; k < 16; k++) m_pkt.push_back(m_hold[8*k +: 8]);
            m_busy = 1;
            m_is_status = 0;
            m_after_status = 0;
        end
        if (drp) begin
            if (m_drop < 65535) m_drop++;
            m_ovf = 1;
        end
        if (ld) begin
            m_hold_full = 1;
            m_hold = bus.frame_data;
        end
        if (trig) m_pending = 1;
        m_hb = (m_hb + 1) % HB;
        m_sync_q = sync;
        m_cfg_q = cfg_width;
    endtask

    // One clock: compare on the falling edge, step the model, return just
    // after the rising edge so the caller can drive the next inputs.
    task automatic tick();
        @(negedge clk);
        check("tx_valid", 32'(bus.tx_valid), 32'(m_valid));
        if (m_valid) check("tx_data", 32'(bus.tx_data), 32'(m_pkt[0]));
        check("frame_ready", 32'(bus.frame_ready), 32'(!m_hold_full));
        check("txOvf", 32'(txOvf), 32'(m_ovf));
        check("frame_count", 32'(frame_count), 32'(m_count));
        if (bus.tx_valid && !prev_valid) rise_q.push_back(cyc);
        if (bus.tx_valid && bus.tx_ready) log_q.push_back(bus.tx_data);
        prev_valid = bus.tx_valid;
        model_step();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [127:0] fd);
        bus.frame_data  = fd;
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
    endtask

    // Start a scenario at a fixed heartbeat phase, well clear of the next heartbeat.
    task automatic align();
        for (int i = 0; i < HB && m_hb != 10; i++) tick();
    endtask

    function automatic logic [127:0] ramp(input logic [7:0] base);
        logic [127:0] fd;
        for (int k = 0; k < 16; k++) fd[8*k +: 8] = base + 8'(k);
        return fd;
    endfunction

    initial begin
        logic [127:0] fd;
        int           low_cnt;

        bus.frame_valid = 1'b0;
        bus.frame_data  = '0;
        bus.tx_ready    = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_frame_ready", 32'(bus.frame_ready), 32'd1);
        check("rst_txOvf", 32'(txOvf), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        rst = 1'b1;

        // First packet after reset is STATUS; next one comes from the heartbeat
        repeat (110) tick();
        check("st0_b0", log_at(0), 32'hA5);
        check("st0_b1", log_at(1), 32'h00);
        check("st0_b2", log_at(2), 32'h00);
        check("st0_b3", log_at(3), 32'h00);
        check("st_count", 32'(log_q.size()), 32'd8);
        check("hb_spacing", 32'(rise_q.size() >= 2 ? rise_q[1] - rise_q[0] : -1), 32'd100);

        // Single frame 0x00..0x0F at full rate
        align();
        log_q.delete();
        present(ramp(8'h00));
        low_cnt = bus.frame_ready ? 0 : 1;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (!bus.frame_ready) low_cnt++;
        end
        check("frame_ready_low", 32'(low_cnt), 32'd19);
        check("f1_len", 32'(log_q.size()), 32'd17);
        check("f1_hdr", log_at(0), 32'h5A);
        for (int k = 0; k < 16; k++) check("f1_byte", log_at(k + 1), 32'(k));
        check("f1_count", 32'(frame_count), 32'd1);

        // UART ready one cycle in three
        align();
        log_q.delete();
        fd = {$urandom(), $urandom(), $urandom(), $urandom()};
        present(fd);
        for (int i = 0; i < 70; i++) begin
            bus.tx_ready = (cyc % 3 == 0);
            tick();
        end
        bus.tx_ready = 1'b1;
        check("f2_hdr", log_at(0), 32'h5A);
        for (int k = 0; k < 16; k++) check("f2_byte", log_at(k + 1), 32'(fd[8*k +: 8]));
        repeat (20) tick();

        // Held frame, a dropped frame and a sync change mid-frame
        align();
        log_q.delete();
        present(ramp(8'h10));
        tick();
        sync = 1'b1;
        present(ramp(8'h40));
        repeat (60) tick();
        check("f3_hdr", log_at(0), 32'h5A);
        check("f3_last", log_at(16), 32'h1F);
        check("s3_hdr", log_at(17), 32'hA5);
        check("s3_sync", 32'(log_at(18) >> 7) & 32'd1, 32'd1);
        check("s3_ovf", 32'(log_at(18) >> 4) & 32'd1, 32'd1);
        check("s3_drop_hi", log_at(19), 32'h00);
        check("s3_drop_lo", log_at(20), 32'h01);
        check("ovf_cleared", 32'(txOvf), 32'd0);

        // Frame held during a status packet goes before the next status
        align();
        log_q.delete();
        cfg_width = 2'd1;
        tick();
        tick();
        present(ramp(8'h60));
        cfg_width = 2'd2;
        repeat (50) tick();
        check("as_s1_hdr", log_at(0), 32'hA5);
        check("as_s1_stat", log_at(1), 32'hA3);
        check("as_f_hdr", log_at(4), 32'h5A);
        check("as_f_b0", log_at(5), 32'h60);
        check("as_s2_hdr", log_at(21), 32'hA5);
        check("as_s2_stat", log_at(22), 32'hC4);

        // Reset in the middle of a frame
        align();
        log_q.delete();
        present(ramp(8'h80));
        for (int i = 0; i < 40 && log_q.size() < 8; i++) tick();
        check("mid_frame_reached", 32'(log_q.size()), 32'd8);
        rst = 1'b0;
        #1;
        check("mr_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("mr_frame_ready", 32'(bus.frame_ready), 32'd1);
        check("mr_frame_count", 32'(frame_count), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        log_q.delete();
        rst = 1'b1;
        repeat (12) tick();
        check("mr_first_hdr", log_at(0), 32'hA5);
        check("mr_count_after", 32'(frame_count), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bus.frame_valid = ($urandom_range(0, 11) == 0);
            bus.frame_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.tx_ready    = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 149) == 0) sync = ~sync;
            if ($urandom_range(0, 149) == 0) cfg_width = 2'($urandom_range(0, 3));
            tick();
        end
        bus.frame_valid = 1'b0;
        bus.tx_ready    = 1'b1;
        repeat (60) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
